// File: rtl/zxuno_reg_master_if.sv
// Agent request/response handshake plus Z80-style I/O bus between zxuno_reg_master and its neighbours.
interface zxuno_reg_master_if;
  logic        req;
  logic        ready;
  logic        req_wr;
  logic [7:0]  req_reg;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        cache_inv;
  logic [15:0] a;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [7:0]  din;

  modport master (
    input  req, req_wr, req_reg, req_data, cache_inv, din,
    output ready, rsp_valid, rsp_data, a, iorq_n, rd_n, wr_n, dout, dout_oe
  );

  modport slave (
    output req, req_wr, req_reg, req_data, cache_inv, din,
    input  ready, rsp_valid, rsp_data, a, iorq_n, rd_n, wr_n, dout, dout_oe
  );
endinterface

// File: rtl/zxuno_reg_master.sv
// ZX-UNO register initiator: FC3B address phase (skipped on cache hit), then FD3B data phase.
// Miss latency 2*(SETUP+STROBE+1)+1, hit SETUP+STROBE+2; ready only in IDLE, one request in flight.
module zxuno_reg_master #(
  parameter logic [15:0] IOADDR        = 16'hFC3B,
  parameter logic [15:0] IODATA        = 16'hFD3B,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input logic                clk,
  input logic                rst_n,
  zxuno_reg_master_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE
  } state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        wr_q, wr_nxt;
  logic [7:0]  reg_q, reg_nxt;
  logic [7:0]  data_q, data_nxt;
  logic [7:0]  cache, cache_nxt;
  logic        cache_valid, cache_valid_nxt;
  logic        ready_q, ready_nxt;
  logic        rsp_valid_q, rsp_valid_nxt;
  logic [7:0]  rsp_data_q, rsp_data_nxt;
  logic [15:0] a_q, a_nxt;
  logic        iorq_n_q, iorq_n_nxt;
  logic        rd_n_q, rd_n_nxt;
  logic        wr_n_q, wr_n_nxt;
  logic [7:0]  dout_q, dout_nxt;
  logic        oe_q, oe_nxt;
  logic        hit;

  // An invalidate on the accepting edge wins over the stored tag.
  assign hit = cache_valid && !bus.cache_inv && (bus.req_reg == cache);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    wr_nxt          = wr_q;
    reg_nxt         = reg_q;
    data_nxt        = data_q;
    cache_nxt       = cache;
    cache_valid_nxt = cache_valid;
    rsp_valid_nxt   = 1'b0;
    rsp_data_nxt    = rsp_data_q;
    a_nxt           = a_q;
    dout_nxt        = dout_q;
    oe_nxt          = oe_q;
    rd_n_nxt        = 1'b1;
    wr_n_nxt        = 1'b1;
    case (state)
      IDLE: begin
        if (bus.req) begin
          wr_nxt   = bus.req_wr;
          reg_nxt  = bus.req_reg;
          data_nxt = bus.req_data;
          cnt_nxt  = SETUP_LD;
          if (hit) begin
            state_nxt = D_SETUP;
            a_nxt     = IODATA;
            dout_nxt  = bus.req_data;
            oe_nxt    = bus.req_wr;
          end else begin
            state_nxt = A_SETUP;
            a_nxt     = IOADDR;
            dout_nxt  = bus.req_reg;
            oe_nxt    = 1'b1;
          end
        end
      end
      A_SETUP: begin
        wr_n_nxt = (cnt != 4'd0);
        if (cnt == 4'd0) begin
          state_nxt = A_STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      A_STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt       = A_HOLD;
          cache_nxt       = reg_q;
          cache_valid_nxt = 1'b1;
        end else begin
          cnt_nxt  = cnt - 4'd1;
          wr_n_nxt = 1'b0;
        end
      end
      A_HOLD: begin
        state_nxt = D_SETUP;
        cnt_nxt   = SETUP_LD;
        a_nxt     = IODATA;
        dout_nxt  = data_q;
        oe_nxt    = wr_q;
      end
      D_SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = D_STROBE;
          cnt_nxt   = STROBE_LD;
          wr_n_nxt  = !wr_q;
          rd_n_nxt  = wr_q;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      D_STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt = D_HOLD;
          if (!wr_q) rsp_data_nxt = bus.din;
        end else begin
          cnt_nxt  = cnt - 4'd1;
          wr_n_nxt = !wr_q;
          rd_n_nxt = wr_q;
        end
      end
      D_HOLD: begin
        state_nxt     = DONE;
        rsp_valid_nxt = 1'b1;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.cache_inv) cache_valid_nxt = 1'b0;
    iorq_n_nxt = rd_n_nxt & wr_n_nxt;
    ready_nxt  = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      wr_q        <= 1'b0;
      reg_q       <= 8'h00;
      data_q      <= 8'h00;
      cache       <= 8'h00;
      cache_valid <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      a_q         <= 16'h0000;
      iorq_n_q    <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      dout_q      <= 8'h00;
      oe_q        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      wr_q        <= wr_nxt;
      reg_q       <= reg_nxt;
      data_q      <= data_nxt;
      cache       <= cache_nxt;
      cache_valid <= cache_valid_nxt;
      ready_q     <= ready_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_data_q  <= rsp_data_nxt;
      a_q         <= a_nxt;
      iorq_n_q    <= iorq_n_nxt;
      rd_n_q      <= rd_n_nxt;
      wr_n_q      <= wr_n_nxt;
      dout_q      <= dout_nxt;
      oe_q        <= oe_nxt;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.a         = a_q;
  assign bus.iorq_n    = iorq_n_q;
  assign bus.rd_n      = rd_n_q;
  assign bus.wr_n      = wr_n_q;
  assign bus.dout      = dout_q;
  assign bus.dout_oe   = oe_q;
endmodule
